pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter ISA_WIDTH, default 30, meaning the instruction word width.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 4, meaning the opcode field width, taken from the MSBs of the instruction.
REQ-003 SHALL have parameter ADDR_WIDTH_MEM, default 16, meaning the instruction address width.
REQ-004 SHALL have parameter START_ADDR, default 16'h0001, meaning the first fetch address.
REQ-005 SHALL have parameter INT_ADDR, default 16'h8000, meaning the interrupt service address.
REQ-006 SHALL have parameter END_OPCODE, default 4'hF, meaning the opcode that halts fetch.
REQ-007 SHALL have port clk, input, 1 bit: system clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port addr_ins, output, ADDR_WIDTH_MEM bits: address presented to the instruction cache.
REQ-010 SHALL have port ins_cache_rdy, input, 1 bit: cache ready to serve addr_ins.
REQ-011 SHALL have port instruction, input, ISA_WIDTH bits: instruction word from the cache.
REQ-012 SHALL have port ins_valid, input, OPCODE_WIDTH bits: all-ones means instruction is valid.
REQ-013 SHALL have port ir, output, ISA_WIDTH bits: instruction register to AP_ctrl.
REQ-014 SHALL have port ir_valid, output, 1 bit: ir holds an unconsumed instruction.
REQ-015 SHALL have port ctrl_ready, input, 1 bit: AP_ctrl accepts ir this cycle.
REQ-016 SHALL have port jmp_en, input, 1 bit: AP_ctrl branch request, sampled with the ir handshake.
REQ-017 SHALL have port jmp_addr, input, ADDR_WIDTH_MEM bits: branch target.
REQ-018 SHALL have port int_req, input, 1 bit: level interrupt request.
REQ-019 SHALL have port int_ack, output, 1 bit: single-cycle pulse on interrupt entry.
REQ-020 SHALL have port int_ret, input, 1 bit: single-cycle pulse marking return from interrupt.
REQ-021 SHALL have port halted, output, 1 bit: END_OPCODE has been issued and accepted.

Function
REQ-022 SHALL implement the states IDLE, FETCH, CAPTURE, ISSUE, INT_WAIT and HALT as a registered FSM.
REQ-023 SHALL move from IDLE to FETCH one cycle after reset release.
REQ-024 SHALL, in FETCH, drive addr_ins = pc, wait while ins_cache_rdy=0, and enter CAPTURE on the first cycle ins_cache_rdy=1.
REQ-025 SHALL, in CAPTURE, hold addr_ins stable and wait for ins_valid all-ones.
REQ-026 SHALL, on ins_valid all-ones, latch instruction into ir, assert ir_valid the next cycle, and enter ISSUE.
REQ-027 SHALL treat any ins_valid value other than all-ones as not valid.
REQ-028 SHALL, in ISSUE, hold ir and ir_valid=1 until ctrl_ready=1; handshake completes in that cycle; ir_valid drops the next cycle.
REQ-029 SHALL, on handshake with jmp_en=1, load pc <= jmp_addr; otherwise pc <= pc+1, wrapping modulo 2^ADDR_WIDTH_MEM, except that pc SHALL never become INT_ADDR by increment (skip to INT_ADDR+1).
REQ-030 SHALL, on handshake with opcode = END_OPCODE, enter HALT, set halted=1 and cease fetching; jmp_en is ignored then.
REQ-031 SHALL, on handshake with int_req=1, no interrupt active and opcode not END_OPCODE, save the next pc (per REQ-029) to ret_pc, set pc <= INT_ADDR, pulse int_ack for one cycle, set int_active, and enter FETCH.
REQ-032 SHALL sample interrupts only at the ISSUE handshake; int_req during FETCH/CAPTURE waits and is not lost while held high.
REQ-033 SHALL ignore int_req while int_active=1 (no nesting).
REQ-034 SHALL, after the interrupt instruction handshake, enter INT_WAIT and re-present INT_ADDR (FETCH again) until int_ret arrives.
REQ-035 SHALL, on int_ret, clear int_active, load pc <= ret_pc and enter FETCH; int_ret while int_active=0 SHALL be ignored.
REQ-036 SHALL give minimum latency ins_cache_rdy seen -> ir_valid of 2 cycles when ins_valid is all-ones in the CAPTURE entry cycle.
REQ-037 SHALL make addr_ins change only on state entry to FETCH (glitch-free, registered).

Reset
REQ-038 SHALL, on rst=0, asynchronously force state=IDLE, pc=START_ADDR, addr_ins=START_ADDR, ir=0, ir_valid=0, int_ack=0, halted=0, int_active=0, ret_pc=0.
REQ-039 SHALL, on reset mid-transaction, discard any captured instruction; the first fetch after release is START_ADDR.
REQ-040 SHALL leave HALT only through reset.

Verification
REQ-041 Bench SHALL cover basic fetch: rdy after 3 cycles, valid=4'hF with instruction 30'h0123_4567 -> addr_ins=1, ir=30'h0123_4567, ir_valid high until ctrl_ready, next addr_ins=2.
REQ-042 Bench SHALL cover backpressure: ctrl_ready low for 5 cycles -> ir and ir_valid stable, no addr change, pc advances once.
REQ-043 Bench SHALL cover jump: handshake at pc=5 with jmp_en=1, jmp_addr=16'h0040 -> next addr_ins=16'h0040.
REQ-044 Bench SHALL cover interrupt: int_req=1 at handshake of pc=7 -> int_ack one pulse, addr_ins=16'h8000, held until int_ret; second int_req ignored; after int_ret addr_ins=8.
REQ-045 Bench SHALL cover halt: instruction with opcode 4'hF accepted -> halted=1, no further FETCH, addr_ins frozen.
REQ-046 Bench SHALL cover async reset during CAPTURE -> all outputs at reset values immediately, first fetch after release at addr_ins=1.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction fetch front end feeding AP_ctrl, with a single-level interrupt and halt.
// Latency: cache ready -> ir_valid is 2 cycles minimum (FETCH then CAPTURE); addr_ins is registered on FETCH entry.
// Backpressure: ir/ir_valid are held in ISSUE until ctrl_ready; no new fetch is issued while an instruction is unconsumed.
module pc_fetch #(
    parameter int                        ISA_WIDTH      = 30,
    parameter int                        OPCODE_WIDTH   = 4,
    parameter int                        ADDR_WIDTH_MEM = 16,
    parameter logic [ADDR_WIDTH_MEM-1:0] START_ADDR     = 16'h0001,
    parameter logic [ADDR_WIDTH_MEM-1:0] INT_ADDR       = 16'h8000,
    parameter logic [OPCODE_WIDTH-1:0]   END_OPCODE     = 4'hF
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    input  logic                      ins_cache_rdy,
    input  logic [ISA_WIDTH-1:0]      instruction,
    input  logic [OPCODE_WIDTH-1:0]   ins_valid,
    output logic [ISA_WIDTH-1:0]      ir,
    output logic                      ir_valid,
    input  logic                      ctrl_ready,
    input  logic                      jmp_en,
    input  logic [ADDR_WIDTH_MEM-1:0] jmp_addr,
    input  logic                      int_req,
    output logic                      int_ack,
    input  logic                      int_ret,
    output logic                      halted
);

    // Fetch sequencer states.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_CAPTURE  = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_INT_WAIT = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    logic [2:0]                state_q;
    logic [2:0]                state_d;
    logic [ADDR_WIDTH_MEM-1:0] pc_q;
    logic [ADDR_WIDTH_MEM-1:0] pc_d;
    logic [ADDR_WIDTH_MEM-1:0] pc_inc;
    logic [ADDR_WIDTH_MEM-1:0] pc_seq;
    logic [ADDR_WIDTH_MEM-1:0] ret_pc_q;
    logic                      int_active_q;
    logic                      ret_pend_q;
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic                      ins_ok;
    logic                      handshake;
    logic                      is_end;
    logic                      take_int;
    logic                      take_ret;
    logic                      enter_fetch;

    // Opcode of the instruction currently offered to AP_ctrl.
    assign opcode    = ir[ISA_WIDTH-1 -: OPCODE_WIDTH];
    assign is_end    = (opcode == END_OPCODE);

    // Only the all-ones pattern marks a valid cache word; anything else is treated as not yet valid.
    assign ins_ok    = &ins_valid;

    // ir_valid is high exactly while in ISSUE, so the handshake is ISSUE plus ctrl_ready.
    assign handshake = (state_q == S_ISSUE) && ctrl_ready;

    // Interrupts are only taken at a handshake, never nested, and never on the halting instruction.
    assign take_int  = handshake && !is_end && int_req && !int_active_q;

    // Return from interrupt is resolved in INT_WAIT; an int_ret seen earlier in the handler is remembered.
    assign take_ret  = (state_q == S_INT_WAIT) && int_active_q && (int_ret || ret_pend_q);

    // Sequential successor of pc; the interrupt vector is never reached by counting, it is skipped.
    always_comb begin
        pc_inc = pc_q + 1'b1;
        if (pc_inc == INT_ADDR) begin
            pc_inc = INT_ADDR + 1'b1;
        end
    end

    // Address that follows the instruction being handed over: branch target or sequential successor.
    assign pc_seq = jmp_en ? jmp_addr : pc_inc;

    // Next-state logic of the fetch sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (ins_cache_rdy) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (ins_ok) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ctrl_ready) begin
                    if (is_end) begin
                        state_d = S_HALT;
                    end else if (int_active_q) begin
                        // Handler instruction consumed: park until the return decision.
                        state_d = S_INT_WAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_INT_WAIT: begin
                // Either return to ret_pc or re-present the vector; both refetch.
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next pc: branch/increment on a normal handshake, vector on interrupt entry, ret_pc on return.
    // Inside the handler pc stays at the vector and jmp_en is not honoured.
    always_comb begin
        pc_d = pc_q;
        if (handshake && !is_end) begin
            if (take_int) begin
                pc_d = INT_ADDR;
            end else if (!int_active_q) begin
                pc_d = pc_seq;
            end
        end else if (take_ret) begin
            pc_d = ret_pc_q;
        end
    end

    assign enter_fetch = (state_d == S_FETCH) && (state_q != S_FETCH);

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pc register; addr_ins only reloads on entry to FETCH so it stays steady through CAPTURE and ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= START_ADDR;
            addr_ins <= START_ADDR;
        end else begin
            pc_q <= pc_d;
            if (enter_fetch) begin
                addr_ins <= pc_d;
            end
        end
    end

    // Instruction register: capture the valid cache word, drop ir_valid after the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            if ((state_q == S_CAPTURE) && ins_ok) begin
                ir       <= instruction;
                ir_valid <= 1'b1;
            end else if (handshake) begin
                ir_valid <= 1'b0;
            end
        end
    end

    // Interrupt context: return address, active flag, pending return and the one-cycle acknowledge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_pc_q     <= '0;
            int_active_q <= 1'b0;
            ret_pend_q   <= 1'b0;
            int_ack      <= 1'b0;
        end else begin
            int_ack <= take_int;
            if (take_int) begin
                ret_pc_q     <= pc_seq;
                int_active_q <= 1'b1;
            end else if (take_ret) begin
                int_active_q <= 1'b0;
            end
            if (take_ret) begin
                ret_pend_q <= 1'b0;
            end else if (int_active_q && int_ret) begin
                ret_pend_q <= 1'b1;
            end
        end
    end

    // Halt flag: set when the end opcode is accepted; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted <= 1'b0;
        end else if (handshake && is_end) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed stimulus for pc_fetch with a transaction-level reference model checked every cycle.
// Latency: stimulus driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: ctrl_ready is held low for chosen cycle counts to exercise ISSUE holding.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] addr_ins;
    logic        ins_cache_rdy;
    logic [29:0] instruction;
    logic [3:0]  ins_valid;
    logic [29:0] ir;
    logic        ir_valid;
    logic        ctrl_ready;
    logic        jmp_en;
    logic [15:0] jmp_addr;
    logic        int_req;
    logic        int_ack;
    logic        int_ret;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    pc_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .addr_ins      (addr_ins),
        .ins_cache_rdy (ins_cache_rdy),
        .instruction   (instruction),
        .ins_valid     (ins_valid),
        .ir            (ir),
        .ir_valid      (ir_valid),
        .ctrl_ready    (ctrl_ready),
        .jmp_en        (jmp_en),
        .jmp_addr      (jmp_addr),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .int_ret       (int_ret),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: word 1 is the basic-fetch pattern, word 9 halts, others carry their address.
    function automatic logic [29:0] mem_word(input logic [15:0] a);
        if (a == 16'h0001) return 30'h0123_4567;
        if (a == 16'h0009) return {4'hF, 10'h000, a};
        return {4'h3, 10'h155, a};
    endfunction

    // Sequential successor: wrap at 2^16 and never land on the interrupt vector.
    function automatic logic [15:0] next_seq(input logic [15:0] a);
        int n;
        n = (int'(a) + 1) % 65536;
        if (n == 32'h8000) n = 32'h8001;
        return n[15:0];
    endfunction

    // The cache returns the word at whatever address the fetch unit presents.
    assign instruction = mem_word(addr_ins);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected fetch address, interrupt context and halt, advanced per handshake.
    logic [15:0] m_addr       = 16'h0001;
    logic [15:0] m_ret_pc     = 16'h0000;
    logic [29:0] m_word       = 30'h0;
    logic        m_int_active = 1'b0;
    logic        m_ret_pend   = 1'b0;
    logic        m_halted     = 1'b0;
    logic        m_ack        = 1'b0;
    logic        m_irv_low    = 1'b0;
    logic        m_wait       = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_addr_ins", 32'(addr_ins), 32'h0001);
            chk("rst_ir_valid", 32'(ir_valid), 32'h0);
            chk("rst_halted", 32'(halted), 32'h0);
            chk("rst_int_ack", 32'(int_ack), 32'h0);
            m_addr       = 16'h0001;
            m_ret_pc     = 16'h0000;
            m_int_active = 1'b0;
            m_ret_pend   = 1'b0;
            m_halted     = 1'b0;
            m_ack        = 1'b0;
            m_irv_low    = 1'b0;
            m_wait       = 1'b0;
        end else begin
            chk("addr_ins", 32'(addr_ins), 32'(m_addr));
            chk("halted", 32'(halted), 32'(m_halted));
            chk("int_ack", 32'(int_ack), 32'(m_ack));
            if (m_irv_low || m_halted) chk("ir_valid_low", 32'(ir_valid), 32'h0);
            if (ir_valid) chk("ir", 32'(ir), 32'(mem_word(m_addr)));
            m_ack     = 1'b0;
            m_irv_low = 1'b0;
            if (int_ret && m_int_active) m_ret_pend = 1'b1;
            if (m_wait) begin
                m_wait = 1'b0;
                if (m_ret_pend) begin
                    m_addr       = m_ret_pc;
                    m_int_active = 1'b0;
                    m_ret_pend   = 1'b0;
                end
            end else if (ir_valid && ctrl_ready && !m_halted) begin
                m_word    = mem_word(m_addr);
                m_irv_low = 1'b1;
                if (m_word[29:26] == 4'hF) begin
                    m_halted = 1'b1;
                end else if (m_int_active) begin
                    m_wait = 1'b1;
                end else if (int_req) begin
                    m_ret_pc     = jmp_en ? jmp_addr : next_seq(m_addr);
                    m_addr       = 16'h8000;
                    m_int_active = 1'b1;
                    m_ack        = 1'b1;
                end else begin
                    m_addr = jmp_en ? jmp_addr : next_seq(m_addr);
                end
            end
        end
    end

    // Serve one fetch: ready after rdy_dly cycles, ins_valid all-ones after val_dly more; returns cycles to ir_valid.
    task automatic get_ins(input int rdy_dly, input int val_dly, input logic ret_pulse, output int lat);
        int n;
        ins_cache_rdy = 1'b0;
        ins_valid     = 4'h0;
        repeat (rdy_dly) tick();
        ins_cache_rdy = 1'b1;
        n = 0;
        while (ir_valid !== 1'b1 && n < 40) begin
            ins_valid = (n >= val_dly) ? 4'hF : 4'hE;
            int_ret   = ret_pulse && (n == 1);
            tick();
            n++;
        end
        int_ret       = 1'b0;
        ins_cache_rdy = 1'b0;
        ins_valid     = 4'h0;
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL get_ins_timeout actual=no_ir_valid required=ir_valid addr=%h", addr_ins);
        end
        lat = n;
    endtask

    // Hold ctrl_ready low for hold cycles, then complete the handshake with the given branch request.
    task automatic accept(input int hold, input logic jmp, input logic [15:0] ja);
        repeat (hold) tick();
        ctrl_ready = 1'b1;
        jmp_en     = jmp;
        jmp_addr   = ja;
        tick();
        ctrl_ready = 1'b0;
        jmp_en     = 1'b0;
        jmp_addr   = 16'h0;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        ins_cache_rdy = 1'b0;
        ins_valid = 4'h0;
        ctrl_ready = 1'b0;
        jmp_en = 1'b0;
        jmp_addr = 16'h0;
        int_req = 1'b0;
        int_ret = 1'b0;
        #2 rst = 1'b0;
        repeat (3) tick();
        chk("reset_addr", 32'(addr_ins), 32'h0001);
        chk("reset_ir", 32'(ir), 32'h0);
        chk("reset_ir_valid", 32'(ir_valid), 32'h0);
        rst = 1'b1;

        // Basic fetch with backpressure.
        get_ins(3, 0, 1'b0, lat);
        chk("basic_latency", 32'(lat), 32'd2);
        chk("basic_ir", 32'(ir), 32'h0123_4567);
        chk("basic_addr", 32'(addr_ins), 32'h0001);
        repeat (5) tick();
        chk("bp_ir_valid", 32'(ir_valid), 32'h1);
        chk("bp_ir", 32'(ir), 32'h0123_4567);
        chk("bp_addr", 32'(addr_ins), 32'h0001);
        accept(0, 1'b0, 16'h0);
        chk("next_addr", 32'(addr_ins), 32'h0002);
        chk("drop_ir_valid", 32'(ir_valid), 32'h0);

        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);
        // Delayed ins_valid with non-all-ones pattern; stray int_ret while no interrupt is active.
        get_ins(1, 3, 1'b1, lat);
        chk("slow_valid_latency", 32'(lat), 32'd4);
        accept(2, 1'b0, 16'h0);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);

        // Jump at pc=5.
        get_ins(0, 0, 1'b0, lat);
        chk("pc5_addr", 32'(addr_ins), 32'h0005);
        accept(1, 1'b1, 16'h0040);
        chk("jump_addr", 32'(addr_ins), 32'h0040);

        // Increment skips the vector and wraps at the top.
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b1, 16'h7FFF);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);
        chk("skip_vector", 32'(addr_ins), 32'h8001);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b1, 16'hFFFF);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);
        chk("wrap_addr", 32'(addr_ins), 32'h0000);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b1, 16'h0007);
        chk("back_to_7", 32'(addr_ins), 32'h0007);

        // Interrupt raised during fetch of pc=7, taken at its handshake.
        int_req = 1'b1;
        get_ins(1, 1, 1'b0, lat);
        accept(1, 1'b0, 16'h0);
        chk("int_ack_pulse", 32'(int_ack), 32'h1);
        chk("int_vector", 32'(addr_ins), 32'h8000);
        tick();
        chk("int_ack_single", 32'(int_ack), 32'h0);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);
        chk("no_nested_ack", 32'(int_ack), 32'h0);
        tick();
        chk("vector_held", 32'(addr_ins), 32'h8000);
        int_req = 1'b0;
        get_ins(0, 0, 1'b1, lat);
        accept(0, 1'b0, 16'h0);
        tick();
        chk("return_addr", 32'(addr_ins), 32'h0008);

        // Halt at pc=9; jmp_en on that handshake must be ignored.
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);
        get_ins(0, 0, 1'b0, lat);
        accept(0, 1'b1, 16'h0123);
        chk("halted_set", 32'(halted), 32'h1);
        chk("halt_addr", 32'(addr_ins), 32'h0009);
        ins_cache_rdy = 1'b1;
        ins_valid     = 4'hF;
        repeat (8) tick();
        chk("halt_frozen_addr", 32'(addr_ins), 32'h0009);
        chk("halt_no_ir_valid", 32'(ir_valid), 32'h0);
        chk("halt_stays", 32'(halted), 32'h1);
        ins_cache_rdy = 1'b0;
        ins_valid     = 4'h0;

        // Reset leaves HALT; then an asynchronous reset lands in CAPTURE.
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        get_ins(1, 0, 1'b0, lat);
        accept(0, 1'b0, 16'h0);
        chk("post_halt_addr", 32'(addr_ins), 32'h0002);
        ins_cache_rdy = 1'b1;
        ins_valid     = 4'hE;
        tick();
        tick();
        ins_cache_rdy = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_addr", 32'(addr_ins), 32'h0001);
        chk("async_ir", 32'(ir), 32'h0);
        chk("async_ir_valid", 32'(ir_valid), 32'h0);
        chk("async_halted", 32'(halted), 32'h0);
        chk("async_int_ack", 32'(int_ack), 32'h0);
        ins_valid = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        get_ins(2, 0, 1'b0, lat);
        chk("refetch_addr", 32'(addr_ins), 32'h0001);
        chk("refetch_ir", 32'(ir), 32'h0123_4567);
        accept(0, 1'b0, 16'h0);
        chk("refetch_next", 32'(addr_ins), 32'h0002);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
